// File: rtl/shift_pkg.sv
// shift_pkg: select codes and entry layout shared by the shift result path
package shift_pkg;
   localparam logic [1:0] SEL_PASS     = 2'b00;
   localparam logic [1:0] SEL_SHL      = 2'b01;
   localparam logic [1:0] SEL_SHR      = 2'b10;
   localparam logic [1:0] SEL_PASS_ALT = 2'b11;
   localparam int RES_W = 32;
   typedef struct packed {
      logic [RES_W-1:0] result;
      logic [1:0]       sel;
      logic             zero;
      logic             neg;
      logic             shifted;
   } shift_entry_t;
endpackage

// File: rtl/shift_flags.sv
// shift_flags: zero/negative/shifted flags for one shifter result
module shift_flags
   import shift_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] result,
   input  logic [1:0]       sel,
   output logic             zero,
   output logic             neg,
   output logic             shifted
);
   // flags derived purely from the captured value and select code
   always_comb begin
      zero    = result == '0;
      neg     = result[WIDTH-1];
      shifted = sel == SEL_SHL || sel == SEL_SHR;
   end
endmodule

// File: rtl/shift_result_stage.sv
// shift_result_stage: two-entry skid buffer for shifter results with flags and delivery count
module shift_result_stage
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic [1:0]       in_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [1:0]       out_sel,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_shifted,
   output logic [CNT_W-1:0] done_count
);
   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic [1:0]       sel;
      logic             zero;
      logic             neg;
      logic             shifted;
   } entry_t;
   entry_t           head_q, head_d, tail_q, tail_d, in_e;
   logic [1:0]       count_q, count_d;
   logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic [CNT_W-1:0] done_q, done_d;
   logic             push, pop, zero, neg, shifted;
   shift_flags #(.WIDTH(WIDTH)) u_flags (
      .result (in_result),
      .sel    (in_sel),
      .zero   (zero),
      .neg    (neg),
      .shifted(shifted)
   );
   // occupancy, head/tail steering and handshake flags for the next cycle
   always_comb begin
      push        = in_valid && in_ready_q;
      pop         = out_valid_q && out_ready;
      in_e        = '{result: in_result, sel: in_sel, zero: zero, neg: neg, shifted: shifted};
      count_d     = (push && !pop) ? count_q + 2'd1 : (pop && !push) ? count_q - 2'd1 : count_q;
      head_d      = (push && (count_q == 2'd0 || pop)) ? in_e : (pop && count_q == 2'd2) ? tail_q : head_q;
      tail_d      = (push && !pop && count_q == 2'd1) ? in_e : tail_q;
      in_ready_d  = count_d != 2'd2;
      out_valid_d = count_d != 2'd0;
      done_d      = done_q + CNT_W'(pop);
   end
   // state registers; reset drops any buffered entries
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q     <= 2'd0;
         head_q      <= '0;
         tail_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         done_q      <= '0;
      end else begin
         count_q     <= count_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end
   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_result  = head_q.result;
   assign out_sel     = head_q.sel;
   assign out_zero    = head_q.zero;
   assign out_neg     = head_q.neg;
   assign out_shifted = head_q.shifted;
   assign done_count  = done_q;
endmodule

// File: tb/tb_shift_result_stage.sv
// tb_shift_result_stage: queue-model checks plus directed literal checks
module tb_shift_result_stage;
   localparam int W = 32;
   localparam int CW = 4;
   logic          clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
   logic [W-1:0]  in_result = '0;
   logic [1:0]    in_sel = '0;
   logic          in_ready, out_valid, out_zero, out_neg, out_shifted;
   logic [W-1:0]  out_result;
   logic [1:0]    out_sel;
   logic [CW-1:0] done_count;
   int total = 0, bad = 0;

   shift_result_stage #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_sel(in_sel), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_sel(out_sel),
      .out_zero(out_zero), .out_neg(out_neg), .out_shifted(out_shifted),
      .done_count(done_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a queue of accepted results; head shown on outputs, last head held when empty
   typedef struct {logic [W-1:0] r; logic [1:0] s;} item_t;
   item_t q[$];
   logic [W-1:0] m_r;
   logic [1:0]   m_s;
   bit m_in_ready, m_out_valid, m_live = 0;
   int m_done;

   always @(posedge clk) begin
      if (!rst_n) begin
         q.delete();
         m_done = 0; m_r = '0; m_s = '0; m_live = 1;
      end else if (m_live) begin
         bit push, pop;
         push = in_valid && m_in_ready;
         pop  = m_out_valid && out_ready;
         if (pop) begin void'(q.pop_front()); m_done = (m_done + 1) % 16; end
         if (push) q.push_back('{in_result, in_sel});
         if (q.size() > 0) begin m_r = q[0].r; m_s = q[0].s; end
      end
      m_in_ready  = q.size() != 2;
      m_out_valid = q.size() != 0;
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (m_live) begin
         chk("in_ready", in_ready, m_in_ready);
         chk("out_valid", out_valid, m_out_valid);
         chk("done_count", done_count, m_done);
         chk("out_result", out_result, m_r);
         chk("out_sel", out_sel, m_s);
         chk("out_zero", out_zero, (m_out_valid || m_r != 0 || m_s != 0) ? (m_r == 0) : 1'b0);
         chk("out_neg", out_neg, m_r[W-1]);
         chk("out_shifted", out_shifted, m_s == 2'b01 || m_s == 2'b10);
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      step(); step();
      chk("rst in_ready", in_ready, 1);
      chk("rst out_valid", out_valid, 0);
      chk("rst done", done_count, 0);
      chk("rst out_result", out_result, 0);
      chk("rst out_zero", out_zero, 0);
      rst_n = 1;
      // single transfer
      in_valid = 1; in_result = 32'h10; in_sel = 2'b01; out_ready = 1;
      step();
      in_valid = 0;
      chk("single valid", out_valid, 1);
      chk("single result", out_result, 32'h10);
      chk("single zero", out_zero, 0);
      chk("single neg", out_neg, 0);
      chk("single shifted", out_shifted, 1);
      step();
      chk("single done", done_count, 1);
      chk("single drained", out_valid, 0);
      // flags
      in_valid = 1; in_result = 32'h0; in_sel = 2'b00;
      step();
      chk("flag zero", out_zero, 1);
      chk("flag zero shifted", out_shifted, 0);
      in_result = 32'h8000_0000; in_sel = 2'b10;
      step();
      chk("flag neg", out_neg, 1);
      chk("flag neg shifted", out_shifted, 1);
      in_result = 32'h5; in_sel = 2'b11;
      step();
      chk("flag alt shifted", out_shifted, 0);
      in_valid = 0;
      step();
      // backpressure and skid
      out_ready = 0; in_valid = 1; in_result = 1; in_sel = 2'b01;
      step();
      in_result = 2;
      step();
      chk("skid in_ready", in_ready, 0);
      chk("skid head A", out_result, 1);
      in_result = 3;
      step(); step();
      chk("stall head A", out_result, 1);
      chk("stall in_ready", in_ready, 0);
      out_ready = 1;
      step();
      chk("pop A head B", out_result, 2);
      chk("pop A in_ready", in_ready, 1);
      step();
      chk("pop B head C", out_result, 3);
      in_valid = 0;
      step();
      chk("bp drained", out_valid, 0);
      // streaming after a fresh reset
      rst_n = 0; step(); rst_n = 1;
      for (int i = 0; i < 100; i++) begin
         in_valid = 1; in_result = i; in_sel = 2'(i);
         step();
         chk("stream result", out_result, i);
         chk("stream valid", out_valid, 1);
      end
      in_valid = 0;
      step();
      chk("stream done", done_count, 100 % 16);
      // mid-operation reset with a full buffer
      out_ready = 0; in_valid = 1; in_result = 7;
      step();
      in_result = 8;
      step();
      in_valid = 0;
      chk("full in_ready", in_ready, 0);
      out_ready = 1; rst_n = 0;
      step();
      rst_n = 1;
      chk("midrst valid", out_valid, 0);
      chk("midrst in_ready", in_ready, 1);
      chk("midrst done", done_count, 0);
      step(); step();
      chk("midrst no stale", out_valid, 0);
      // counter wrap: 17 pops on a 4-bit counter
      for (int i = 0; i < 17; i++) begin
         in_valid = 1; in_result = 32'h100 + i; in_sel = 2'b10;
         step();
      end
      in_valid = 0;
      step();
      chk("wrap done", done_count, 1);
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
